pipeline_buffer: RTL and testbench

Parametrised elastic buffer placed between two pipeline stages, replacing the fixed single-entry IF/ID, ID/EX, EX/MEM registers.
- Carries a WIDTH-bit payload (stage signals packed by the instantiating pipeline top).
- Holds up to DEPTH entries.
- Handshake is valid/ready on both sides.
- A synchronous flush discards all held entries on jump mispredict.

---
 rtl/pipeline_buffer.sv | 76 +++++++
 tb/tb_pipeline_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_buffer.sv
// pipeline_buffer: elastic valid/ready buffer (DEPTH entries of WIDTH bits) between two pipeline stages.
// Optional macro PIPELINE_BUFFER_BYPASS_EN: an empty buffer forwards valid_in/data_in combinationally.
module pipeline_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_empty, w_push, w_pop;

  // DEPTH need not be a power of two, so wrap on an explicit compare
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_empty   = (r_count == '0);
  assign ready_out = (r_count != FULL);
  assign count     = r_count;

`ifdef PIPELINE_BUFFER_BYPASS_EN
  logic w_byp_take;
  // an empty buffer hands the input straight through; consumed entries are never stored
  assign w_byp_take = w_empty & valid_in & ready_in;
  assign valid_out  = w_empty ? (valid_in & ~flush) : 1'b1;
  assign data_out   = w_empty ? data_in : r_mem[r_rd_ptr];
  assign w_push     = valid_in & ready_out & ~w_byp_take;
  assign w_pop      = ~w_empty & ready_in;
`else
  assign valid_out  = ~w_empty;
  assign data_out   = r_mem[r_rd_ptr];
  assign w_push     = valid_in & ready_out;
  assign w_pop      = valid_out & ready_in;
`endif

  // storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_buffer.sv
// Bench for pipeline_buffer: directed vector table (DEPTH=2), streaming/flush/reset sequences,
// and random traffic on DEPTH=2 and DEPTH=3 instances against a queue-based reference model.
module tb_pipeline_buffer;
  logic        clk = 1'b0;
  logic        reset, flush, valid_in, ready_in;
  logic [31:0] data_in;
  logic        vo2, ro2, vo3, ro3;
  logic [31:0] do2, do3;
  logic [1:0]  cnt2, cnt3;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q2[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  pipeline_buffer #(.WIDTH(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_out(ro2),
    .data_in(data_in), .valid_out(vo2), .ready_in(ready_in), .data_out(do2), .count(cnt2));

  pipeline_buffer #(.WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_out(ro3),
    .data_in(data_in), .valid_out(vo3), .ready_in(ready_in), .data_out(do3), .count(cnt3));

  typedef struct {
    logic f, v, r;
    logic [31:0] d;
    logic evo, ero;
    logic [31:0] ed;
    int ecnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most D entries; flush empties it, a full FIFO refuses input.
  task automatic model_chk(input int sel);
    logic [31:0] q[$];
    int d, n;
    logic avo, aro, evo, pop, push, take;
    logic [31:0] ado, edo;
    logic [1:0] acnt;
    string tag;
    if (sel == 0) begin q = q2; d = 2; avo = vo2; aro = ro2; ado = do2; acnt = cnt2; tag = "d2"; end
    else          begin q = q3; d = 3; avo = vo3; aro = ro3; ado = do3; acnt = cnt3; tag = "d3"; end
    n = q.size();
    take = 1'b0;
    edo = 32'h0;
`ifdef PIPELINE_BUFFER_BYPASS_EN
    if (n == 0) begin
      evo = valid_in && !flush;
      edo = data_in;
      take = valid_in && ready_in;
    end else begin
      evo = 1'b1;
      edo = q[0];
    end
`else
    evo = (n != 0);
    if (n != 0) edo = q[0];
`endif
    chk({tag, " model valid_out"}, 32'(avo), 32'(evo));
    chk({tag, " model ready_out"}, 32'(aro), 32'(n < d));
    chk({tag, " model count"}, 32'(acnt), 32'(n));
    if (evo) chk({tag, " model data_out"}, ado, edo);
    if (flush) q.delete();
    else begin
      pop  = (n != 0) && ready_in;
      push = valid_in && (n < d) && !take;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(data_in);
    end
    if (sel == 0) q2 = q; else q3 = q;
  endtask

  task automatic tick();
    #3;
    model_chk(0);
    model_chk(1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    @(posedge clk); #1;
    q2.delete(); q3.delete();
    reset = 1'b0;
  endtask

  initial begin
    vec_t tbl[20];
    tbl[0]  = '{0, 0, 0, 32'h0,         0, 1, 32'h0,         0};
    tbl[1]  = '{0, 1, 0, 32'hA5A5_0001, 0, 1, 32'h0,         0};
    tbl[2]  = '{0, 0, 0, 32'h0,         1, 1, 32'hA5A5_0001, 1};
    tbl[3]  = '{0, 0, 1, 32'h0,         1, 1, 32'hA5A5_0001, 1};
    tbl[4]  = '{0, 0, 0, 32'h0,         0, 1, 32'h0,         0};
    tbl[5]  = '{0, 1, 0, 32'h11,        0, 1, 32'h0,         0};
    tbl[6]  = '{0, 1, 0, 32'h22,        1, 1, 32'h11,        1};
    tbl[7]  = '{0, 1, 0, 32'h33,        1, 0, 32'h11,        2};
    tbl[8]  = '{0, 1, 0, 32'h33,        1, 0, 32'h11,        2};
    tbl[9]  = '{0, 1, 1, 32'h33,        1, 0, 32'h11,        2};
    tbl[10] = '{0, 1, 1, 32'h33,        1, 1, 32'h22,        1};
    tbl[11] = '{0, 0, 1, 32'h0,         1, 1, 32'h33,        1};
    tbl[12] = '{0, 0, 0, 32'h0,         0, 1, 32'h0,         0};
    tbl[13] = '{0, 1, 0, 32'h44,        0, 1, 32'h0,         0};
    tbl[14] = '{0, 1, 0, 32'h55,        1, 1, 32'h44,        1};
    tbl[15] = '{1, 1, 0, 32'h66,        1, 0, 32'h44,        2};
    tbl[16] = '{0, 0, 0, 32'h0,         0, 1, 32'h0,         0};
    tbl[17] = '{0, 1, 0, 32'h77,        0, 1, 32'h0,         0};
    tbl[18] = '{0, 0, 1, 32'h0,         1, 1, 32'h77,        1};
    tbl[19] = '{0, 0, 0, 32'h0,         0, 1, 32'h0,         0};

    // reset state
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    #12;
    chk("reset valid_out", 32'(vo2), 32'h0);
    chk("reset ready_out", 32'(ro2), 32'h1);
    chk("reset count",     32'(cnt2), 32'h0);
    chk("reset count d3",  32'(cnt3), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // directed table on the DEPTH=2 instance
    for (int i = 0; i < 20; i++) begin
      logic evo;
      logic [31:0] ed;
      flush = tbl[i].f; valid_in = tbl[i].v; ready_in = tbl[i].r; data_in = tbl[i].d;
      evo = tbl[i].evo; ed = tbl[i].ed;
`ifdef PIPELINE_BUFFER_BYPASS_EN
      if (tbl[i].ecnt == 0) begin evo = tbl[i].v && !tbl[i].f; ed = tbl[i].d; end
`endif
      #3;
      chk($sformatf("tbl[%0d] valid_out", i), 32'(vo2), 32'(evo));
      chk($sformatf("tbl[%0d] ready_out", i), 32'(ro2), 32'(tbl[i].ero));
      chk($sformatf("tbl[%0d] count", i), 32'(cnt2), 32'(tbl[i].ecnt));
      if (evo) chk($sformatf("tbl[%0d] data_out", i), do2, ed);
      @(posedge clk); #1;
    end

    // streaming through DEPTH=3: one output per cycle, pointers wrap repeatedly
    do_reset();
    for (int k = 0; k < 18; k++) begin
      valid_in = (k < 16); ready_in = 1'b1; data_in = 32'(k);
      #2;
`ifdef PIPELINE_BUFFER_BYPASS_EN
      chk($sformatf("stream[%0d] valid_out", k), 32'(vo3), 32'(k < 16));
      if (k < 16) chk($sformatf("stream[%0d] data_out", k), do3, 32'(k));
`else
      chk($sformatf("stream[%0d] valid_out", k), 32'(vo3), 32'(k >= 1 && k <= 16));
      if (k >= 1 && k <= 16) chk($sformatf("stream[%0d] data_out", k), do3, 32'(k - 1));
`endif
      tick();
    end

    // empty buffer offered 0xDEAD with downstream ready
    do_reset();
    valid_in = 1'b1; ready_in = 1'b1; data_in = 32'hDEAD;
    #2;
`ifdef PIPELINE_BUFFER_BYPASS_EN
    chk("bypass valid_out", 32'(vo2), 32'h1);
    chk("bypass data_out", do2, 32'hDEAD);
`else
    chk("no-bypass valid_out", 32'(vo2), 32'h0);
`endif
    tick();
    valid_in = 1'b0;
    #2;
`ifdef PIPELINE_BUFFER_BYPASS_EN
    chk("bypass count", 32'(cnt2), 32'h0);
`else
    chk("latency1 data_out", do2, 32'hDEAD);
    chk("latency1 count", 32'(cnt2), 32'h1);
`endif
    tick();

    // random traffic on both depths
    do_reset();
    for (int k = 0; k < 400; k++) begin
      flush    = ($urandom_range(0, 11) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 1) == 1);
      data_in  = $urandom;
      tick();
    end

    // asynchronous reset mid-operation drops held entries immediately
    flush = 1'b0; valid_in = 1'b1; ready_in = 1'b0;
    data_in = 32'hC0DE_0001; tick();
    data_in = 32'hC0DE_0002; tick();
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async reset count", 32'(cnt2), 32'h0);
    chk("async reset valid_out", 32'(vo2), 32'h0);
    chk("async reset ready_out", 32'(ro2), 32'h1);
    @(posedge clk); #1;
    q2.delete(); q3.delete();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
